psimd_sat_alu: RTL and testbench

- Parametrised, pipelined packed-SIMD saturating add/subtract unit. Next generation of the ALU's fixed 4x4-bit saturating adder.
- Generalised lane width and lane count. Adds signed/unsigned and add/sub modes, a valid/ready elastic 2-stage pipeline, per-lane saturation reporting and sticky flags.
- Sits in the ALU/EX path. Its result feeds writeback; its flags feed the status register.

---
 rtl/psimd_sat_alu.sv | 187 ++++++++++++++++++
 tb/tb_psimd_sat_alu.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psimd_sat_alu.sv
// psimd_sat_alu: packed-SIMD saturating add/subtract unit with an elastic
// two-stage valid/ready pipeline.
//
// The data word holds LANES independent lanes of LANE_W bits each, where
// lane i = word[i*LANE_W +: LANE_W]. Carries never cross lane boundaries.
//
// Pipeline:
//   S1 registers the operands and the op code.
//   S2 computes each lane, then registers the result and its saturation mask.
//
// Ports:
//   clk, rst      rising-edge clock; synchronous active-high reset
//   in_valid      operand beat valid
//   in_ready      unit can accept a beat (combinational ready chain only)
//   op            00 signed add, 01 signed sub, 10 unsigned add, 11 unsigned sub
//   a, b          packed operands
//   out_valid     result beat valid
//   out_ready     consumer accepts the result beat
//   result        per-lane saturated result (registered)
//   sat_mask      bit i set when lane i was clamped (registered)
//   clr_flags     clear sticky_sat; a coincident output beat still records
//   sticky_sat    accumulated sat_mask over output transfers (registered)
module psimd_sat_alu #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                op,
  input  logic [LANE_W*LANES-1:0]   a,
  input  logic [LANE_W*LANES-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   result,
  output logic [LANES-1:0]          sat_mask,
  input  logic                      clr_flags,
  output logic [LANES-1:0]          sticky_sat
);

  localparam int DW = LANE_W * LANES;

  // One lane: exact LANE_W+1 bit sum/difference, then clamp.
  // The returned value is {saturated, lane_result}.
  function automatic logic [LANE_W:0] sat_lane(input logic [LANE_W-1:0] x,
                                               input logic [LANE_W-1:0] y,
                                               input logic [1:0]        mode);
    logic [LANE_W:0]   wide;
    logic [LANE_W-1:0] res;
    logic              sat;
    wide = {(LANE_W+1){1'b0}};
    res  = {LANE_W{1'b0}};
    sat  = 1'b0;
    case (mode)
      2'b00:   wide = {x[LANE_W-1], x} + {y[LANE_W-1], y};
      2'b01:   wide = {x[LANE_W-1], x} - {y[LANE_W-1], y};
      2'b10:   wide = {1'b0, x} + {1'b0, y};
      2'b11:   wide = {1'b0, x} - {1'b0, y};
      default: wide = {(LANE_W+1){1'b0}};
    endcase
    if (!mode[1]) begin
      // Signed: the top two bits disagree only when the true value lies
      // outside the lane range. The top bit is the true sign, so it picks
      // which bound the lane clamps to.
      if (wide[LANE_W] != wide[LANE_W-1]) begin
        sat = 1'b1;
        res = wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
        res = wide[LANE_W-1:0];
      end
    end else begin
      // Unsigned: the top bit is the carry (add) or the borrow (sub).
      if (wide[LANE_W]) begin
        sat = 1'b1;
        res = mode[0] ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
      end else begin
        res = wide[LANE_W-1:0];
      end
    end
    return {sat, res};
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [DW-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [1:0]      s1_op_q, s1_op_d;
  logic            s2_valid_q, s2_valid_d;
  logic [DW-1:0]   result_q, result_d;
  logic [LANES-1:0] sat_mask_q, sat_mask_d;
  logic [LANES-1:0] sticky_q, sticky_d;
  logic            s2_adv_s, out_xfer_s;
  logic [DW-1:0]   alu_result_s;
  logic [LANES-1:0] alu_mask_s;
  logic [LANE_W:0] lane_s;

  assign s2_adv_s   = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_adv_s;
  assign out_xfer_s = s2_valid_q && out_ready;

  assign out_valid  = s2_valid_q;
  assign result     = result_q;
  assign sat_mask   = sat_mask_q;
  assign sticky_sat = sticky_q;

  // Per-lane arithmetic on the S1 contents.
  always_comb begin
    alu_result_s = {DW{1'b0}};
    alu_mask_s   = {LANES{1'b0}};
    lane_s       = {(LANE_W+1){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lane_s = sat_lane(s1_a_q[i*LANE_W +: LANE_W], s1_b_q[i*LANE_W +: LANE_W], s1_op_q);
      alu_result_s[i*LANE_W +: LANE_W] = lane_s[LANE_W-1:0];
      alu_mask_s[i] = lane_s[LANE_W];
    end
  end

  // Next state for both pipeline stages; stalled stages hold their contents.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    sat_mask_d = sat_mask_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = a;
        s1_b_d  = b;
        s1_op_d = op;
      end else begin
        s1_a_d  = s1_a_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = alu_result_s;
        sat_mask_d = alu_mask_s;
      end else begin
        result_d   = result_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Sticky flags: a clear that coincides with an output transfer keeps
  // that beat's mask.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_flags) begin
      sticky_d = out_xfer_s ? sat_mask_q : {LANES{1'b0}};
    end else if (out_xfer_s) begin
      sticky_d = sticky_q | sat_mask_q;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= {DW{1'b0}};
      s1_b_q     <= {DW{1'b0}};
      s1_op_q    <= 2'b00;
      s2_valid_q <= 1'b0;
      result_q   <= {DW{1'b0}};
      sat_mask_q <= {LANES{1'b0}};
      sticky_q   <= {LANES{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      sat_mask_q <= sat_mask_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule

// File: tb/tb_psimd_sat_alu.sv
// tb_psimd_sat_alu: self-checking bench for psimd_sat_alu.
//
// Instances:
//   dut  - 4 lanes x 4 bits
//   dutw - 2 lanes x 8 bits
//
// Expected beats come from an integer reference model. They are queued when
// a beat is accepted and popped when the DUT transfers a result.
//
// Timing: inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_psimd_sat_alu;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clr_flags;
  logic [1:0]  op;
  logic [15:0] a, b, result;
  logic        in_ready, out_valid;
  logic [3:0]  sat_mask, sticky_sat;

  logic        w_in_valid, w_out_ready, w_clr_flags;
  logic [1:0]  w_op;
  logic [15:0] w_a, w_b, w_result;
  logic        w_in_ready, w_out_valid;
  logic [1:0]  w_sat_mask, w_sticky_sat;

  int errors = 0;
  int checks = 0;
  logic [19:0] q0[$];
  logic [17:0] q1[$];

  always #5 clk = ~clk;

  psimd_sat_alu #(.LANE_W(4), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .sat_mask(sat_mask), .clr_flags(clr_flags), .sticky_sat(sticky_sat));

  psimd_sat_alu #(.LANE_W(8), .LANES(2)) dutw (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
    .sat_mask(w_sat_mask), .clr_flags(w_clr_flags), .sticky_sat(w_sticky_sat));

  // Integer reference model. Returns {mask[15:0], result[31:0]}.
  function automatic logic [47:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] md, input int lw, input int nl);
    logic [31:0] res;
    logic [15:0] msk;
    int ua, ub, sa, sb, r, lo, hi;
    res = 32'h0;
    msk = 16'h0;
    for (int i = 0; i < nl; i++) begin
      ua = int'((x >> (i * lw)) & ((32'd1 << lw) - 32'd1));
      ub = int'((y >> (i * lw)) & ((32'd1 << lw) - 32'd1));
      if (md[1]) begin
        lo = 0;
        hi = (1 << lw) - 1;
        r = md[0] ? ua - ub : ua + ub;
      end else begin
        sa = (ua >= (1 << (lw - 1))) ? ua - (1 << lw) : ua;
        sb = (ub >= (1 << (lw - 1))) ? ub - (1 << lw) : ub;
        lo = -(1 << (lw - 1));
        hi = (1 << (lw - 1)) - 1;
        r = md[0] ? sa - sb : sa + sb;
      end
      if (r > hi) begin
        r = hi;
        msk[i] = 1'b1;
      end else if (r < lo) begin
        r = lo;
        msk[i] = 1'b1;
      end
      res = res | ((32'(r) & ((32'd1 << lw) - 32'd1)) << (i * lw));
    end
    return {msk, res};
  endfunction

  // Stimulus vectors for the 4x4 instance: {op, a, b}.
  function automatic logic [33:0] vec0(input int k);
    case (k)
      0: return {2'b00, 16'h7777, 16'h1111};
      1: return {2'b00, 16'h8888, 16'h8888};
      2: return {2'b01, 16'h8000, 16'h1000};
      3: return {2'b10, 16'hF0F0, 16'h1111};
      4: return {2'b11, 16'h0010, 16'h0101};
      5: return {2'b00, 16'h1234, 16'h4321};
      default: return 34'h0;
    endcase
  endfunction

  // Stimulus vectors for the 2x8 instance: {op, a, b}.
  function automatic logic [33:0] vecw(input int k);
    case (k)
      0: return {2'b00, 16'h1234, 16'h4321};
      1: return {2'b00, 16'h7F7F, 16'h0101};
      2: return {2'b00, 16'h8080, 16'h8080};
      3: return {2'b01, 16'h8000, 16'h1000};
      4: return {2'b10, 16'hF0F0, 16'h1111};
      5: return {2'b11, 16'h0010, 16'h0101};
      default: return 34'h0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    op = 2'b00; a = 16'h0; b = 16'h0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_clr_flags = 1'b0;
    w_op = 2'b00; w_a = 16'h0; w_b = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
    if (sat_mask !== 4'h0) begin errors++; $display("FAIL reset_sat_mask: got %b expected 0000", sat_mask); end
    if (sticky_sat !== 4'h0) begin errors++; $display("FAIL reset_sticky: got %b expected 0000", sticky_sat); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [19:0] exp;
    {op, a, b} = {2'b00, 16'h1234, 16'h4321};
    in_valid = 1'b1;
    q0.push_back({4'b0000, 16'h5555});
    @(posedge clk); #1 in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL lat_valid: out_valid=%b expected 1", out_valid);
    end else begin
      exp = q0.pop_front();
      checks += 2;
      if (result !== exp[15:0]) begin errors++; $display("FAIL lat_result: got %h expected %h", result, exp[15:0]); end
      if (sat_mask !== exp[19:16]) begin errors++; $display("FAIL lat_mask: got %b expected %b", sat_mask, exp[19:16]); end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain: out_valid=%b expected 0", out_valid); end
    q0.delete();
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc;
    logic [19:0] exp;
    logic [47:0] m;
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < 6 && cyc < 40) begin
      if (sent < 6) begin {op, a, b} = vec0(sent); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        m = model({16'h0, a}, {16'h0, b}, op, 4, 4);
        q0.push_back({m[35:32], m[15:0]});
        sent++;
      end
      if (out_valid && out_ready) begin
        got++;
        checks += 2;
        if (q0.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected beat %h", result);
        end else begin
          exp = q0.pop_front();
          if (result !== exp[15:0]) begin errors++; $display("FAIL b2b_result: got %h expected %h", result, exp[15:0]); end
          if (sat_mask !== exp[19:16]) begin errors++; $display("FAIL b2b_mask: got %b expected %b", sat_mask, exp[19:16]); end
        end
      end
      @(posedge clk); #1 cyc++;
    end
    in_valid = 1'b0;
    checks += 2;
    if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d beats expected 6", got); end
    if (cyc != 8) begin errors++; $display("FAIL b2b_throughput: took %0d cycles expected 8", cyc); end
  endtask

  task automatic test_back_pressure();
    int sent, got, cyc;
    logic saw_block;
    logic [19:0] exp;
    logic [47:0] m;
    sent = 0; got = 0; cyc = 0; saw_block = 1'b0;
    while (got < 6 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin {op, a, b} = vec0(sent); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (!in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        m = model({16'h0, a}, {16'h0, b}, op, 4, 4);
        q0.push_back({m[35:32], m[15:0]});
        sent++;
      end
      if (out_valid && !out_ready && q0.size() > 0) begin
        checks++;
        if (result !== q0[0][15:0]) begin errors++; $display("FAIL bp_hold: got %h expected %h", result, q0[0][15:0]); end
      end
      if (out_valid && out_ready) begin
        got++;
        checks += 2;
        if (q0.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected beat %h", result);
        end else begin
          exp = q0.pop_front();
          if (result !== exp[15:0]) begin errors++; $display("FAIL bp_result: got %h expected %h", result, exp[15:0]); end
          if (sat_mask !== exp[19:16]) begin errors++; $display("FAIL bp_mask: got %b expected %b", sat_mask, exp[19:16]); end
        end
      end
      @(posedge clk); #1 cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks += 3;
    if (saw_block !== 1'b1) begin errors++; $display("FAIL bp_in_ready: in_ready never dropped, expected drop"); end
    if (got != 6) begin errors++; $display("FAIL bp_count: got %0d beats expected 6", got); end
    if (cyc != 11) begin errors++; $display("FAIL bp_cycles: took %0d cycles expected 11", cyc); end
  endtask

  task automatic test_sticky();
    logic [3:0] sticky_exp;
    logic [19:0] exp;
    logic [47:0] m;
    out_ready = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    checks++;
    if (sticky_sat !== 4'b0000) begin errors++; $display("FAIL sticky_init: got %b expected 0000", sticky_sat); end
    sticky_exp = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: {op, a, b} = {2'b00, 16'h0007, 16'h0001};
        1: {op, a, b} = {2'b00, 16'h0700, 16'h0100};
        default: {op, a, b} = {2'b01, 16'h8000, 16'h1000};
      endcase
      in_valid = 1'b1;
      m = model({16'h0, a}, {16'h0, b}, op, 4, 4);
      q0.push_back({m[35:32], m[15:0]});
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1 clr_flags = (k == 2);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL sticky_beat_timeout: out_valid=%b expected 1", out_valid);
      end else begin
        exp = q0.pop_front();
        checks++;
        if (sat_mask !== exp[19:16]) begin errors++; $display("FAIL sticky_mask: got %b expected %b", sat_mask, exp[19:16]); end
      end
      @(posedge clk); #1 clr_flags = 1'b0;
      sticky_exp = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0101 : 4'b1000;
      checks++;
      if (sticky_sat !== sticky_exp) begin errors++; $display("FAIL sticky_acc%0d: got %b expected %b", k, sticky_sat, sticky_exp); end
    end
    clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    checks++;
    if (sticky_sat !== 4'b0000) begin errors++; $display("FAIL sticky_clr: got %b expected 0000", sticky_sat); end
    q0.delete();
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      {op, a, b} = vec0(k);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full: in_ready=%b expected 0", in_ready); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid: out_valid=%b expected 1", out_valid); end
    if (sticky_sat !== 4'b1111) begin errors++; $display("FAIL rstmid_sticky_pre: got %b expected 1111", sticky_sat); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    q0.delete();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    if (result !== 16'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0000", result); end
    if (sticky_sat !== 4'h0) begin errors++; $display("FAIL rstmid_sticky: got %b expected 0000", sticky_sat); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    {op, a, b} = {2'b00, 16'h0001, 16'h0001};
    in_valid = 1'b1;
    q0.push_back({4'b0000, 16'h0002});
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_post_valid: out_valid=%b expected 1", out_valid);
    end else begin
      exp = q0.pop_front();
      checks++;
      if (result !== exp[15:0]) begin errors++; $display("FAIL rstmid_post_result: got %h expected %h", result, exp[15:0]); end
    end
    @(posedge clk); #1;
    q0.delete();
  endtask

  task automatic test_wide();
    int sent, got, cyc;
    logic [17:0] exp;
    logic [47:0] m;
    sent = 0; got = 0; cyc = 0;
    w_out_ready = 1'b1;
    while (got < 6 && cyc < 40) begin
      if (sent < 6) begin {w_op, w_a, w_b} = vecw(sent); w_in_valid = 1'b1; end
      else w_in_valid = 1'b0;
      @(negedge clk);
      if (w_in_valid && w_in_ready) begin
        m = model({16'h0, w_a}, {16'h0, w_b}, w_op, 8, 2);
        q1.push_back({m[33:32], m[15:0]});
        sent++;
      end
      if (w_out_valid && w_out_ready) begin
        got++;
        checks += 2;
        if (q1.size() == 0) begin
          errors++; $display("FAIL wide_extra: unexpected beat %h", w_result);
        end else begin
          exp = q1.pop_front();
          if (w_result !== exp[15:0]) begin errors++; $display("FAIL wide_result: got %h expected %h", w_result, exp[15:0]); end
          if (w_sat_mask !== exp[17:16]) begin errors++; $display("FAIL wide_mask: got %b expected %b", w_sat_mask, exp[17:16]); end
        end
      end
      @(posedge clk); #1 cyc++;
    end
    w_in_valid = 1'b0;
    checks += 2;
    if (got != 6) begin errors++; $display("FAIL wide_count: got %0d beats expected 6", got); end
    if (w_sticky_sat !== 2'b11) begin errors++; $display("FAIL wide_sticky: got %b expected 11", w_sticky_sat); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_back_pressure();
    test_sticky();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
